mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the core's instruction-fetch port and its data load/store port.
- Sits between cpu_core and memory and drives memRead/memWrite/memAddr/memDataIn.
- Each requester uses a req/ack handshake. The arbiter sequences exactly one memory access at a time, with a fixed memory access latency.

Parameters:
- MEM_LAT, 1, cycles memRead/memWrite is held before memDataOut is sampled or the write is complete; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RES  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  DW  fetched word; valid in the if_ack cycle and held until the next fetch ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  AW  data address; stable while d_req is high.
- d_wdata  in  DW  store data; stable while d_req is high.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DW  load result; valid in the d_ack cycle; not updated by stores.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- memAddr  out  AW  memory address.
- memDataIn  out  DW  memory write data.
- memDataOut  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RES high at an edge):
  - state goes to IDLE and the latency counter clears.
  - All outputs go to 0: if_ack, d_ack, if_rdata, d_rdata, memRead, memWrite, memAddr, memDataIn, busy.
  - Last-grant clears to "data".
  - An in-flight access is abandoned and no ack is issued for it.
- IDLE:
  - Memory strobes are 0.
  - If any req is high, select a winner, latch its addr/we/wdata into internal registers, and go to ACCESS next cycle.
  - Default arbitration (fixed priority): data beats fetch.
- ACCESS:
  - memAddr and memDataIn are driven from the latched registers.
  - Exactly one strobe is high: memRead for a fetch or a load, memWrite for a store.
  - The counter runs from 0 to MEM_LAT-1 and the state stays in ACCESS for MEM_LAT cycles.
  - On the last ACCESS cycle, memDataOut is captured into the winner's rdata register (reads only), and the state moves to DONE.
- DONE:
  - Strobes are 0, memAddr holds its value, and the winner's ack is 1 for this cycle only; the state then returns to IDLE.
  - Both acks are never high in the same cycle.
- Latency: a req first seen high in IDLE at cycle t gives strobes in t+1..t+MEM_LAT and ack at t+MEM_LAT+1. Minimum back-to-back spacing is MEM_LAT+2 cycles.
- Requesters must not re-assert for a new transaction in the ack cycle. A req still high in the cycle after ack is treated as a new request.
- Simultaneous if_req and d_req in IDLE: the loser stays pending and is granted at the next IDLE. The loser's inputs are not sampled until its grant.
- Req dropped mid-transaction (protocol violation): the access still completes and the ack is still issued. The latched registers make the arbiter immune to input changes after grant.
- Widths: the counter is 4 bits. Addresses pass through unmodified, with no alignment check.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie in IDLE, the requester that did not win the last grant wins. Last-grant updates at each grant.
- Undefined: fixed data-over-fetch priority, and the last-grant register is not synthesized.
- Single-requester behaviour and all timing are identical in both builds.

Decomposition:
- Package mem_arb_pkg:
  - state encoding ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2.
  - grant IDs GNT_IF = 1'b0, GNT_D = 1'b1.
- One combinational sub-module, arb_grant_select: inputs if_req, d_req, last_gnt; outputs gnt_valid, gnt_id. It contains the MEM_ARB_RR_EN choice so the FSM is build-independent.

Test Plan:
- Reset mid-access: MEM_LAT=3, start a fetch, assert RES in the 2nd ACCESS cycle -> no if_ack ever, all outputs 0 the next cycle, busy=0.
- Lone fetch: MEM_LAT=1, if_req with if_addr=0x100, memory returns 0xDEADBEEF -> memRead=1 for exactly 1 cycle at addr 0x100, if_ack 2 cycles after the req cycle, if_rdata=0xDEADBEEF.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678, MEM_LAT=2 -> memWrite high 2 cycles with memAddr=0x200 and memDataIn=0x12345678, d_ack 3 cycles after req, d_rdata unchanged, memRead never high.
- Tie, fixed priority: if_req and d_req rise together, load from 0x300 and fetch from 0x0 -> data access first, d_ack, then the fetch. if_ack exactly MEM_LAT+2 cycles after d_ack.
- Tie, MEM_ARB_RR_EN build: two consecutive simultaneous pairs of requests -> first pair order data then fetch; second pair order fetch then data.
- Mid-transaction change: change d_addr from 0x400 to 0x500 during ACCESS -> memAddr stays 0x400 and d_ack is still issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Grant IDs identify the fetch and data requesters throughout the design.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arbState_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int CNT_W = 4;

  // Fetches and loads read memory; only a data-port store writes.
  function automatic logic isWriteAccess(input logic gntId, input logic we);
    return (gntId == GNT_D) && we;
  endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational winner selection between fetch and data requesters.
// Build option MEM_ARB_RR_EN selects round-robin; otherwise data beats fetch.
module arb_grant_select
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that lost the previous grant goes next.
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_id    = GNT_D;
    if (if_req && d_req) begin
      gnt_id = ~last_gnt;
    end else if (if_req) begin
      gnt_id = GNT_IF;
    end
  end
`else
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt_id    = GNT_D;
    if (if_req && !d_req) begin
      gnt_id = GNT_IF;
    end
  end

  logic unusedLastGnt;
  assign unusedLastGnt = last_gnt;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is data-first.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          memRead,
  output logic          memWrite,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memDataIn,
  input  logic [DW-1:0] memDataOut,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  arbState_t        state;
  logic [CNT_W-1:0] latCnt;
  logic             latId;
  logic             latWe;
  logic             gntValid;
  logic             gntId;
  logic             lastGnt;
  logic             selWe;
  logic [AW-1:0]    selAddr;
  logic [DW-1:0]    selWdata;

  arb_grant_select uGrant (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_gnt  (lastGnt),
    .gnt_valid (gntValid),
    .gnt_id    (gntId)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge CLK) begin
    if (RES) begin
      lastGnt <= GNT_D;
    end else if (state == ST_IDLE && gntValid) begin
      lastGnt <= gntId;
    end
  end
`else
  assign lastGnt = GNT_D;
`endif

  // Only the winner's inputs are looked at; the loser is sampled at its own grant.
  always_comb begin
    selWe    = isWriteAccess(gntId, d_we);
    selAddr  = if_addr;
    selWdata = '0;
    if (gntId == GNT_D) begin
      selAddr  = d_addr;
      selWdata = d_wdata;
    end
  end

  // memAddr/memDataIn double as the latched request, so later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= ST_IDLE;
      latCnt    <= '0;
      latId     <= GNT_IF;
      latWe     <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memDataIn <= '0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gntValid) begin
            state     <= ST_ACCESS;
            latCnt    <= '0;
            latId     <= gntId;
            latWe     <= selWe;
            memAddr   <= selAddr;
            memDataIn <= selWdata;
            memRead   <= ~selWe;
            memWrite  <= selWe;
            busy      <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (latCnt == LAST_CNT) begin
            state    <= ST_DONE;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            if (latId == GNT_D) begin
              d_ack <= 1'b1;
              if (!latWe) begin
                d_rdata <= memDataOut;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= memDataOut;
            end
          end else begin
            latCnt <= latCnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          memRead  <= 1'b0;
          memWrite <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a MEM_LAT=3 instance for most steps
// plus a MEM_LAT=1 instance for the minimum-latency fetch.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RES;

  logic        ifReq, ifAck, dReq, dWe, dAck, memRead, memWrite, busy;
  logic [31:0] ifAddr, ifRdata, dAddr, dWdata, dRdata, memAddr, memDataIn, memDataOut;

  logic        fIfReq, fIfAck, fDReq, fDWe, fDAck, fMemRead, fMemWrite, fBusy;
  logic [31:0] fIfAddr, fIfRdata, fDAddr, fDWdata, fDRdata, fMemAddr, fMemDataIn, fMemDataOut;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  // Memory model: read data is a tagged copy of the address.
  assign memDataOut = 32'hA000_0000 | memAddr;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RES(RES),
    .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(dAck), .d_rdata(dRdata),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
    .memDataIn(memDataIn), .memDataOut(memDataOut), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dutLat1 (
    .CLK(CLK), .RES(RES),
    .if_req(fIfReq), .if_addr(fIfAddr), .if_ack(fIfAck), .if_rdata(fIfRdata),
    .d_req(fDReq), .d_we(fDWe), .d_addr(fDAddr), .d_wdata(fDWdata),
    .d_ack(fDAck), .d_rdata(fDRdata),
    .memRead(fMemRead), .memWrite(fMemWrite), .memAddr(fMemAddr),
    .memDataIn(fMemDataIn), .memDataOut(fMemDataOut), .busy(fBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One isolated request on the LAT instance, checked cycle by cycle.
  task automatic applyStimulus(input logic isData, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRd);
    logic isWr;
    isWr = isData && we;
    if (isData) begin
      dReq = 1'b1; dWe = we; dAddr = addr; dWdata = wdata;
    end else begin
      ifReq = 1'b1; ifAddr = addr;
    end
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput("acc_addr", memAddr, addr);
      checkOutput("acc_rd", 32'(memRead), 32'(!isWr));
      checkOutput("acc_wr", 32'(memWrite), 32'(isWr));
      if (isWr) checkOutput("acc_wdata", memDataIn, wdata);
      checkOutput("acc_noack", 32'({dAck, ifAck}), 32'd0);
    end
    tick();
    checkOutput("ack_d", 32'(dAck), 32'(isData));
    checkOutput("ack_if", 32'(ifAck), 32'(!isData));
    checkOutput("done_strobes", 32'({memRead, memWrite}), 32'd0);
    checkOutput("done_addr", memAddr, addr);
    if (isData) checkOutput("d_rdata", dRdata, expRd);
    else        checkOutput("if_rdata", ifRdata, expRd);
    ifReq = 1'b0; dReq = 1'b0;
    tick();
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_ack", 32'({dAck, ifAck}), 32'd0);
  endtask

  // Fetch and load raised together; winner first, loser granted at the next IDLE.
  task automatic tiePair(input logic dataFirst, input logic [31:0] ifA, input logic [31:0] dA);
    logic [31:0] firstA, secondA;
    firstA  = dataFirst ? dA : ifA;
    secondA = dataFirst ? ifA : dA;
    ifReq = 1'b1; ifAddr = ifA;
    dReq = 1'b1; dWe = 1'b0; dAddr = dA;
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput("tie1_addr", memAddr, firstA);
      checkOutput("tie1_rd", 32'(memRead), 32'd1);
    end
    tick();
    checkOutput("tie1_ack_d", 32'(dAck), 32'(dataFirst));
    checkOutput("tie1_ack_if", 32'(ifAck), 32'(!dataFirst));
    if (dataFirst) begin
      checkOutput("tie1_rdata", dRdata, 32'hA000_0000 | dA);
      dReq = 1'b0;
    end else begin
      checkOutput("tie1_rdata", ifRdata, 32'hA000_0000 | ifA);
      ifReq = 1'b0;
    end
    tick();
    checkOutput("tie_gap_busy", 32'(busy), 32'd0);
    checkOutput("tie_gap_ack", 32'({dAck, ifAck}), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      tick();
      checkOutput("tie2_addr", memAddr, secondA);
      checkOutput("tie2_rd", 32'(memRead), 32'd1);
    end
    tick();
    checkOutput("tie2_ack_d", 32'(dAck), 32'(!dataFirst));
    checkOutput("tie2_ack_if", 32'(ifAck), 32'(dataFirst));
    if (dataFirst) checkOutput("tie2_rdata", ifRdata, 32'hA000_0000 | ifA);
    else           checkOutput("tie2_rdata", dRdata, 32'hA000_0000 | dA);
    ifReq = 1'b0; dReq = 1'b0;
    tick();
    checkOutput("tie_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ackSeen;
    RES = 1'b1;
    ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    fIfReq = 1'b0; fIfAddr = '0; fDReq = 1'b0; fDWe = 1'b0; fDAddr = '0; fDWdata = '0;
    fMemDataOut = '0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_strobes", 32'({memRead, memWrite}), 32'd0);
    checkOutput("rst_acks", 32'({ifAck, dAck}), 32'd0);
    checkOutput("rst_addr", memAddr, 32'd0);
    checkOutput("rst_wdata", memDataIn, 32'd0);
    checkOutput("rst_if_rdata", ifRdata, 32'd0);
    checkOutput("rst_d_rdata", dRdata, 32'd0);
    RES = 1'b0;

    // Reset lands in the second ACCESS cycle of a fetch.
    ifReq = 1'b1; ifAddr = 32'h40;
    tick();
    checkOutput("mrst_rd1", 32'(memRead), 32'd1);
    checkOutput("mrst_addr", memAddr, 32'h40);
    tick();
    checkOutput("mrst_busy", 32'(busy), 32'd1);
    RES = 1'b1; ifReq = 1'b0;
    tick();
    RES = 1'b0;
    checkOutput("mrst_rd0", 32'(memRead), 32'd0);
    checkOutput("mrst_addr0", memAddr, 32'd0);
    checkOutput("mrst_busy0", 32'(busy), 32'd0);
    checkOutput("mrst_ack0", 32'(ifAck), 32'd0);
    checkOutput("mrst_rdata0", ifRdata, 32'd0);
    ackSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ackSeen = ackSeen | ifAck | dAck;
    end
    checkOutput("mrst_noack", 32'(ackSeen), 32'd0);

    // Minimum latency fetch on the MEM_LAT=1 instance.
    fIfReq = 1'b1; fIfAddr = 32'h100; fMemDataOut = 32'hDEAD_BEEF;
    tick();
    checkOutput("l1_rd", 32'(fMemRead), 32'd1);
    checkOutput("l1_addr", fMemAddr, 32'h100);
    checkOutput("l1_noack", 32'(fIfAck), 32'd0);
    tick();
    checkOutput("l1_rd_off", 32'(fMemRead), 32'd0);
    checkOutput("l1_ack", 32'(fIfAck), 32'd1);
    checkOutput("l1_rdata", fIfRdata, 32'hDEAD_BEEF);
    fIfReq = 1'b0; fMemDataOut = 32'h0;
    tick();
    checkOutput("l1_ack_off", 32'(fIfAck), 32'd0);
    checkOutput("l1_busy", 32'(fBusy), 32'd0);
    checkOutput("l1_hold", fIfRdata, 32'hDEAD_BEEF);

    // Load whose address changes after grant.
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h400;
    tick();
    checkOutput("chg_addr", memAddr, 32'h400);
    checkOutput("chg_rd", 32'(memRead), 32'd1);
    dAddr = 32'h500;
    tick();
    checkOutput("chg_addr2", memAddr, 32'h400);
    tick();
    checkOutput("chg_addr3", memAddr, 32'h400);
    tick();
    checkOutput("chg_ack", 32'(dAck), 32'd1);
    checkOutput("chg_rdata", dRdata, 32'hA000_0400);
    dReq = 1'b0;
    tick();
    checkOutput("chg_idle", 32'(busy), 32'd0);

    // Store leaves d_rdata at the previous load result.
    applyStimulus(1'b1, 1'b1, 32'h200, 32'h1234_5678, 32'hA000_0400);
    // Lone fetch: last grant becomes fetch.
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 32'hA000_0104);
    tiePair(1'b1, 32'h0, 32'h300);
    // Lone load: last grant becomes data.
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 32'hA000_0600);
`ifdef MEM_ARB_RR_EN
    tiePair(1'b0, 32'h8, 32'h308);
`else
    tiePair(1'b1, 32'h8, 32'h308);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
